// File: rtl/ac_eval_pkg.sv
// ac_eval_pkg: shared FSM state type and width helpers for the error-evaluation engine
package ac_eval_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
   function automatic int PW(input int w);
      return 2 * w;
   endfunction
   function automatic int CW(input int w);
      return 2 * w + 1;
   endfunction
   function automatic int SW(input int w);
      return 4 * w;
   endfunction
endpackage

// File: rtl/ac_delay_line.sv
// ac_delay_line: DEPTH-stage register line (DEPTH=0 is a plain wire)
//   clk, rst : clock and synchronous active-high reset
//   d_i      : WIDTH-bit input
//   q_o      : d_i delayed by DEPTH cycles
module ac_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   if (DEPTH == 0) begin : g_wire
      logic unused;
      assign unused = ^{clk, rst};
      assign q_o = d_i;
   end else begin : g_reg
      logic [DEPTH-1:0][WIDTH-1:0] line_q;
      always_ff @(posedge clk) begin
         if (rst) line_q <= '0;
         else begin
            line_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
         end
      end
      assign q_o = line_q[DEPTH-1];
   end
endmodule

// File: rtl/ac_err_eval.sv
// ac_err_eval: exhaustive sweep of an external WxW multiplier, accumulating error metrics
//   clk, rst           : clock and synchronous active-high reset
//   start              : begin a sweep (ignored while busy)
//   busy, done         : sweep in progress / sweep finished (held)
//   op_a, op_b         : registered operands to the multiplier under test
//   approx_prod        : product returned by the multiplier under test (LAT cycles later)
//   err_cnt, sum_ed    : count of wrong products, sum of absolute errors
//   max_ed             : largest absolute error, first reached at worst_a/worst_b
module ac_err_eval
   import ac_eval_pkg::*;
#(
   parameter int W   = 8,
   parameter int LAT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [W-1:0]     op_a,
   output logic [W-1:0]     op_b,
   input  logic [PW(W)-1:0] approx_prod,
   output logic [CW(W)-1:0] err_cnt,
   output logic [SW(W)-1:0] sum_ed,
   output logic [PW(W)-1:0] max_ed,
   output logic [W-1:0]     worst_a,
   output logic [W-1:0]     worst_b
);
   localparam int PWD = PW(W);
   localparam int CWD = CW(W);
   localparam int SWD = SW(W);
   state_e state_q, state_d;
   logic [PWD-1:0] idx_q, idx_d;
   logic [7:0] dcnt_q, dcnt_d;
   logic clr, issue;
   logic [W-1:0] op_a_q, op_b_q, da, db, s1_a_q, s1_b_q, worst_a_q, worst_b_q;
   logic op_v_q, dv, s1_v_q;
   logic [PWD-1:0] s1_ap_q, s1_ex_q, ed, max_ed_q;
   logic [CWD-1:0] err_cnt_q;
   logic [SWD-1:0] sum_ed_q;
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      dcnt_d = dcnt_q;
      clr = 1'b0;
      issue = 1'b0;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = ISSUE;
            idx_d = '0;
            clr = 1'b1;
         end
         ISSUE: begin
            issue = 1'b1;
            idx_d = idx_q + 1'b1;
            dcnt_d = '0;
            if (idx_q == '1) state_d = DRAIN;
         end
         DRAIN: begin
            dcnt_d = dcnt_q + 1'b1;
            if (dcnt_q == 8'(LAT + 1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q <= '0;
         dcnt_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         dcnt_q <= dcnt_d;
      end
   end
   // valid bit travels with the operands so stage 1 knows which approx_prod samples belong to the sweep
   ac_delay_line #(.WIDTH(2 * W + 1), .DEPTH(LAT)) u_dl (
      .clk (clk),
      .rst (rst),
      .d_i ({op_v_q, op_a_q, op_b_q}),
      .q_o ({dv, da, db})
   );
   assign ed = s1_ap_q >= s1_ex_q ? s1_ap_q - s1_ex_q : s1_ex_q - s1_ap_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a_q <= '0;
         op_b_q <= '0;
         op_v_q <= 1'b0;
         s1_v_q <= 1'b0;
         s1_ap_q <= '0;
         s1_ex_q <= '0;
         s1_a_q <= '0;
         s1_b_q <= '0;
         err_cnt_q <= '0;
         sum_ed_q <= '0;
         max_ed_q <= '0;
         worst_a_q <= '0;
         worst_b_q <= '0;
      end else begin
         if (issue) {op_b_q, op_a_q} <= idx_q;
         op_v_q <= issue;
         s1_v_q <= dv;
         s1_ap_q <= approx_prod;
         s1_ex_q <= PWD'(da) * PWD'(db);
         s1_a_q <= da;
         s1_b_q <= db;
         if (clr) begin
            err_cnt_q <= '0;
            sum_ed_q <= '0;
            max_ed_q <= '0;
            worst_a_q <= '0;
            worst_b_q <= '0;
         end else if (s1_v_q) begin
            err_cnt_q <= err_cnt_q + CWD'(ed != '0);
            sum_ed_q <= sum_ed_q + SWD'(ed);
            if (ed > max_ed_q) begin
               max_ed_q <= ed;
               worst_a_q <= s1_a_q;
               worst_b_q <= s1_b_q;
            end
         end
      end
   end
   assign busy = state_q == ISSUE || state_q == DRAIN;
   assign done = state_q == DONE;
   assign op_a = op_a_q;
   assign op_b = op_b_q;
   assign err_cnt = err_cnt_q;
   assign sum_ed = sum_ed_q;
   assign max_ed = max_ed_q;
   assign worst_a = worst_a_q;
   assign worst_b = worst_b_q;
endmodule

// File: tb/tb_ac_err_eval.sv
// tb_ac_err_eval: directed sweeps of several engine instances against behavioural multiplier models
module tb_ac_err_eval;
   logic clk = 1'b0;
   logic rst, start;
   always #5 clk = ~clk;
   // W=8: 0 returns zero, 1 clears bit0, 2 exact, 3 exact with LAT=2
   logic [7:0]  a8 [4], b8 [4], wa8 [4], wb8 [4];
   logic [15:0] p8 [4], me8 [4];
   logic [16:0] ec8 [4];
   logic [31:0] se8 [4];
   logic        bz8 [4], dn8 [4];
   // W=4: 0 returns zero, 1 LAT=0 engine fed by a 2-cycle model, 2 LAT=2 engine with the same model
   logic [3:0]  a4 [3], b4 [3], wa4 [3], wb4 [3];
   logic [7:0]  p4 [3], me4 [3];
   logic [8:0]  ec4 [3];
   logic [15:0] se4 [3];
   logic        bz4 [3], dn4 [3];
   logic [15:0] r8_1, r8_2;
   logic [7:0]  m1_1, m1_2, m2_1, m2_2;
   int checks = 0, failures = 0;
   int t8 [4], t4 [3];
   for (genvar g = 0; g < 4; g++) begin : g8
      ac_err_eval #(.W(8), .LAT(g == 3 ? 2 : 0)) u (
         .clk(clk), .rst(rst), .start(start), .busy(bz8[g]), .done(dn8[g]),
         .op_a(a8[g]), .op_b(b8[g]), .approx_prod(p8[g]), .err_cnt(ec8[g]),
         .sum_ed(se8[g]), .max_ed(me8[g]), .worst_a(wa8[g]), .worst_b(wb8[g]));
   end
   for (genvar g = 0; g < 3; g++) begin : g4
      ac_err_eval #(.W(4), .LAT(g == 2 ? 2 : 0)) u (
         .clk(clk), .rst(rst), .start(start), .busy(bz4[g]), .done(dn4[g]),
         .op_a(a4[g]), .op_b(b4[g]), .approx_prod(p4[g]), .err_cnt(ec4[g]),
         .sum_ed(se4[g]), .max_ed(me4[g]), .worst_a(wa4[g]), .worst_b(wb4[g]));
   end
   always @(posedge clk) begin
      r8_1 <= 16'(a8[3]) * 16'(b8[3]);
      r8_2 <= r8_1;
      m1_1 <= 8'(a4[1]) * 8'(b4[1]);
      m1_2 <= m1_1;
      m2_1 <= 8'(a4[2]) * 8'(b4[2]);
      m2_2 <= m2_1;
   end
   always_comb begin
      p8[0] = '0;
      p8[1] = (16'(a8[1]) * 16'(b8[1])) & 16'hFFFE;
      p8[2] = 16'(a8[2]) * 16'(b8[2]);
      p8[3] = r8_2;
      p4[0] = '0;
      p4[1] = m1_2;
      p4[2] = m2_2;
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   initial begin
      rst = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) t8[i] = 0;
      for (int i = 0; i < 3; i++) t4[i] = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", 64'(bz8[0]), 0);
      chk("rst_done", 64'(dn8[0]), 0);
      chk("rst_ops", 64'({a8[0], b8[0]}), 0);
      chk("rst_metrics", 64'({ec8[0], se8[0], me8[0], wa8[0], wb8[0]}), 0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", 64'(bz8[0]), 1);
      chk("done_after_start", 64'(dn8[0]), 0);
      repeat (1000) @(posedge clk);
      #1;
      chk("mid_op_a", 64'(a8[0]), 231);
      chk("mid_op_b", 64'(b8[0]), 3);
      chk("mid_err_cnt", 64'(ec8[0]), 739);
      chk("mid_sum_ed", 64'(se8[0]), 176925);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_busy", 64'(bz8[0]), 0);
      chk("abort_done", 64'(dn8[0]), 0);
      chk("abort_ops", 64'({a8[0], b8[0]}), 0);
      chk("abort_metrics", 64'({ec8[0], se8[0], me8[0], wa8[0], wb8[0]}), 0);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 70000; c++) begin
         @(posedge clk);
         #1;
         start = (c == 1000);
         for (int i = 0; i < 4; i++) if (dn8[i] && t8[i] == 0) t8[i] = c;
         for (int i = 0; i < 3; i++) if (dn4[i] && t4[i] == 0) t4[i] = c;
         if (dn8[0] && dn8[1] && dn8[2] && dn8[3]) break;
      end
      start = 1'b0;
      chk("zero_done_t", 64'(t8[0]), 65538);
      chk("zero_err_cnt", 64'(ec8[0]), 65025);
      chk("zero_sum_ed", 64'(se8[0]), 1065369600);
      chk("zero_max_ed", 64'(me8[0]), 65025);
      chk("zero_worst", 64'({wa8[0], wb8[0]}), 64'h0000_FFFF);
      chk("bit0_err_cnt", 64'(ec8[1]), 16384);
      chk("bit0_sum_ed", 64'(se8[1]), 16384);
      chk("bit0_max_ed", 64'(me8[1]), 1);
      chk("bit0_worst", 64'({wa8[1], wb8[1]}), 64'h0101);
      chk("exact_done_t", 64'(t8[2]), 65538);
      chk("exact_metrics", 64'({ec8[2], se8[2], me8[2], wa8[2], wb8[2]}), 0);
      chk("lat2_done_t", 64'(t8[3]), 65540);
      chk("lat2_metrics", 64'({ec8[3], se8[3], me8[3], wa8[3], wb8[3]}), 0);
      chk("w4_done_t", 64'(t4[0]), 258);
      chk("w4_err_cnt", 64'(ec4[0]), 225);
      chk("w4_sum_ed", 64'(se4[0]), 14400);
      chk("w4_max_ed", 64'(me4[0]), 225);
      chk("w4_worst", 64'({wa4[0], wb4[0]}), 64'hFF);
      chk("w4_misaligned_nonzero", 64'(ec4[1] != 0), 1);
      chk("w4_lat2_done_t", 64'(t4[2]), 260);
      chk("w4_lat2_metrics", 64'({ec4[2], se4[2], me4[2]}), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", 64'(dn8[3]), 1);
      chk("busy_clear", 64'(bz8[3]), 0);
      chk("zero_err_cnt_held", 64'(ec8[0]), 65025);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
